// File: rtl/prng_scheduler.sv
// prng_scheduler: round-robin random-byte scheduler driving external LFSR step/seed strobes.
// Define PRNG_SCHED_RESEED_EN to reseed from the delivered byte every RESEED_PERIOD grants.
module prng_scheduler #(
    parameter int          STEPS         = 8,
    parameter logic [23:0] TICK_DIV      = 24'd10_000_000,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          RESEED_PERIOD = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic        rvalid,
    output logic [7:0]  rdata,
    input  logic [7:0]  mux_byte,
    output logic        lfsr16_step,
    output logic        lfsr8_step,
    output logic        seed_load,
    output logic [15:0] seed,
    output logic        tick,
    output logic        busy
);
    typedef enum logic [1:0] {S_SEED, S_IDLE, S_STEP, S_CAPTURE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  step_cnt_q, step_cnt_d;
    logic        winner_q, winner_d, last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [23:0] tick_cnt_q;
    logic        s16, s8, sl;
`ifdef PRNG_SCHED_RESEED_EN
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] seed_q, seed_d;
    assign seed = seed_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= 8'd0;
            seed_q     <= SEED;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            seed_q     <= seed_d;
        end
    end
`else
    assign seed = SEED;
`endif
    assign tick = ena && tick_cnt_q == TICK_DIV - 24'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_SEED;
            step_cnt_q <= 4'd0;
            winner_q   <= 1'b0;
            last_q     <= 1'b1;
            gnt_q      <= 2'b00;
            rdata_q    <= 8'd0;
            tick_cnt_q <= 24'd0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            winner_q   <= winner_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            rdata_q    <= rdata_d;
            tick_cnt_q <= (!ena || tick) ? 24'd0 : tick_cnt_q + 24'd1;
        end
    end
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        winner_d   = winner_q;
        last_d     = last_q;
        gnt_d      = 2'b00;
        rdata_d    = rdata_q;
        s16        = 1'b0;
        s8         = 1'b0;
        sl         = 1'b0;
`ifdef PRNG_SCHED_RESEED_EN
        byte_cnt_d = byte_cnt_q;
        seed_d     = seed_q;
`endif
        case (state_q)
            S_SEED: begin
                sl      = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (ena && req != 2'b00) begin
                    winner_d   = (req == 2'b11) ? ~last_q : req[1];
                    step_cnt_d = 4'(STEPS - 1);
                    state_d    = S_STEP;
                end else if (tick) begin
                    s16 = 1'b1;
                    s8  = 1'b1;
                end
            end
            S_STEP: begin
                if (!ena) begin
                    state_d = S_IDLE;
                end else begin
                    s16        = 1'b1;
                    s8         = step_cnt_q[1:0] == 2'd0;
                    step_cnt_d = step_cnt_q - 4'd1;
                    state_d    = (step_cnt_q == 4'd0) ? S_CAPTURE : S_STEP;
                end
            end
            S_CAPTURE: begin
                if (!ena) begin
                    state_d = S_IDLE;
                end else begin
                    rdata_d         = mux_byte;
                    gnt_d[winner_q] = 1'b1;
                    last_d          = winner_q;
                    state_d         = S_IDLE;
`ifdef PRNG_SCHED_RESEED_EN
                    // The grant still goes out; the extra SEED cycle reloads both LFSRs.
                    if (byte_cnt_q == 8'(RESEED_PERIOD - 1)) begin
                        state_d    = S_SEED;
                        seed_d     = SEED ^ {8'h00, mux_byte};
                        byte_cnt_d = 8'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = S_SEED;
        endcase
    end
    assign lfsr16_step = s16 && !reset;
    assign lfsr8_step  = s8 && !reset;
    assign seed_load   = sl && !reset;
    assign gnt         = gnt_q;
    assign rvalid      = |gnt_q;
    assign rdata       = rdata_q;
    assign busy        = state_q != S_IDLE;
endmodule

// File: tb/tb_prng_scheduler.sv
// tb_prng_scheduler: directed scoreboard bench; mux_byte models a datapath that counts lfsr16_step pulses.
module tb_prng_scheduler;
    logic        clk = 1'b0, reset = 1'b1, ena = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [7:0]  mux = 8'd0;
    logic [1:0]  gnt;
    logic        rvalid, lfsr16_step, lfsr8_step, seed_load, tick, busy;
    logic [7:0]  rdata;
    logic [15:0] seed;

    prng_scheduler #(.STEPS(8), .TICK_DIV(24'd4), .SEED(16'hACE1), .RESEED_PERIOD(4)) dut (
        .clk(clk), .reset(reset), .ena(ena), .req(req), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .mux_byte(mux), .lfsr16_step(lfsr16_step), .lfsr8_step(lfsr8_step),
        .seed_load(seed_load), .seed(seed), .tick(tick), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (lfsr16_step) mux <= mux + 8'd1;

    typedef struct {logic [1:0] g; logic [7:0] d; int c;} exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0, c16 = 0, c8 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d, input int c);
        sb.push_back('{g, d, c});
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy !== 1'b0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (busy && lfsr16_step) c16++;
            if (busy && lfsr8_step) c8++;
            if (rvalid || gnt != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", {29'd0, gnt, rvalid}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("gnt", 32'(gnt), 32'(e.g));
                    chk("rvalid", 32'(rvalid), 1);
                    chk("rdata", 32'(rdata), 32'(e.d));
                    chk("gnt_cycle", cyc, e.c);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, first_t, last_t, nt;
        logic [7:0] m, b, prev;
        ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_seed_load", 32'(seed_load), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_seed", 32'(seed), 32'h ACE1);
        chk("rst_strobes", {29'd0, lfsr16_step, lfsr8_step, tick}, 0);
        reset = 1'b0;
        #1;
        chk("seed_load_on", 32'(seed_load), 1);
        chk("seed_value", 32'(seed), 32'hACE1);
        @(negedge clk);
        chk("seed_load_once", 32'(seed_load), 0);
        chk("busy_after_seed", 32'(busy), 0);
        // Both requesters held: 01,10,01,10 back to back every 10 cycles.
        @(negedge clk);
        c0 = cyc; m = mux; req = 2'b11;
        push(2'b01, m + 8'd8,  c0 + 10);
        push(2'b10, m + 8'd16, c0 + 20);
        push(2'b01, m + 8'd24, c0 + 30);
        push(2'b10, m + 8'd32, c0 + 40);
        repeat (40) @(negedge clk);
        req = 2'b00;
        b = m + 8'd32;
`ifdef PRNG_SCHED_RESEED_EN
        chk("reseed_load", 32'(seed_load), 1);
        chk("reseed_value", 32'(seed), 32'(16'hACE1 ^ {8'h00, b}));
`else
        chk("no_reseed_load", 32'(seed_load), 0);
        chk("seed_const", 32'(seed), 32'hACE1);
`endif
        // Single pulse on requester 0.
        wait_idle();
        c0 = cyc; m = mux; c16 = 0; c8 = 0; req = 2'b01;
        push(2'b01, m + 8'd8, c0 + 10);
        @(negedge clk);
        req = 2'b00;
        repeat (9) @(negedge clk);
        chk("step16_count", c16, 8);
        chk("step8_count", c8, 2);
        // Background ticks in IDLE.
        @(negedge clk);
        nt = 0; first_t = 0; last_t = 0;
        for (int i = 0; i < 12; i++) begin
            chk("idle_strobes", {30'd0, lfsr16_step, lfsr8_step}, {30'd0, tick, tick});
            if (tick) begin
                if (nt == 0) first_t = cyc;
                last_t = cyc;
                nt++;
            end
            @(negedge clk);
        end
        chk("tick_count", nt, 3);
        chk("tick_period", last_t - first_t, 8);
        for (int i = 0; i < 8 && tick !== 1'b1; i++) @(negedge clk);
        chk("tick_found", 32'(tick), 1);
        c0 = cyc; m = mux; req = 2'b01;
        prev = m + 8'd8;
        push(2'b01, prev, c0 + 10);
        #1;
        chk("tick_dropped", {30'd0, lfsr16_step, lfsr8_step}, 0);
        @(negedge clk);
        chk("step_entered", 32'(busy), 1);
        req = 2'b00;
        repeat (9) @(negedge clk);
        // Abort in the 3rd STEP cycle.
        @(negedge clk);
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        ena = 1'b0;
        #1;
        chk("abort_strobes", {30'd0, lfsr16_step, lfsr8_step}, 0);
        @(negedge clk);
        chk("abort_idle", 32'(busy), 0);
        chk("abort_rdata", 32'(rdata), 32'(prev));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ena_low_quiet", {28'd0, tick, lfsr16_step, lfsr8_step, seed_load}, 0);
        end
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tick_after_ena", 32'(tick), (i == 3) ? 1 : 0);
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
